// File: rtl/mole_round_if.sv
// Handshake bundle between the round engine and the game-state controller,
// plus the player keys and the score/mole outputs shown to the player.
interface mole_round_if #(
  parameter int NUM_HOLES = 4,
  parameter int SCORE_W   = 8
);
  logic                 game_start;
  logic                 game_active;
  logic                 game_end;
  logic [NUM_HOLES-1:0] keys;
  logic [NUM_HOLES-1:0] mole;
  logic [1:0]           hit_miss;
  logic                 control_signal;
  logic                 timer_signal;
  logic [SCORE_W-1:0]   score;
  logic [SCORE_W-1:0]   misses;

  // Round engine side
  modport master (
    input  game_start, game_active, game_end, keys,
    output mole, hit_miss, control_signal, timer_signal, score, misses
  );

  // Controller / player side
  modport slave (
    output game_start, game_active, game_end, keys,
    input  mole, hit_miss, control_signal, timer_signal, score, misses
  );
endinterface

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round engine: places moles from an LFSR, times each mole and
// the whole round, tallies hits and misses, and hands control back to the
// game-state controller through level handshakes.
module mole_round_ctrl #(
  parameter int          NUM_HOLES       = 4,
  parameter int          MOLE_CYCLES     = 50000000,
  parameter int          FEEDBACK_CYCLES = 25000000,
  parameter int          GAME_CYCLES     = 1500000000,
  parameter int          SCORE_W         = 8,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic         clk,
  input  logic         reset_n,
  mole_round_if.master bus
);

  localparam int MC_W = $clog2(MOLE_CYCLES + 1);
  localparam int FC_W = $clog2(FEEDBACK_CYCLES + 1);
  localparam int GC_W = $clog2(GAME_CYCLES + 1);
  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? 16'h0001 : LFSR_SEED;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SPAWN, S_UP, S_REPORT, S_FEEDBACK, S_TIMEOUT, S_END
  } state_t;

  state_t               state_reg;
  logic [15:0]          lfsr_reg;
  logic [NUM_HOLES-1:0] keys_q;
  logic                 start_q;
  logic [NUM_HOLES-1:0] mole_reg;
  logic [NUM_HOLES-1:0] prev_mole_reg;
  logic [1:0]           hit_miss_reg;
  logic                 control_reg;
  logic                 timer_reg;
  logic [SCORE_W-1:0]   score_reg;
  logic [SCORE_W-1:0]   misses_reg;
  logic [MC_W-1:0]      mole_cnt_reg;
  logic [FC_W-1:0]      fb_cnt_reg;
  logic [GC_W-1:0]      game_cnt_reg;

  logic [NUM_HOLES-1:0] key_edge;
  logic                 mole_edge;
  logic                 wrong_edge;
  logic [7:0]           idx_raw;
  logic [7:0]           idx_inc;
  logic [NUM_HOLES-1:0] raw_oh;
  logic [NUM_HOLES-1:0] inc_oh;
  logic [NUM_HOLES-1:0] spawn_oh;

  // Only rising key edges count, so a held key can never score twice.
  assign key_edge   = bus.keys & ~keys_q;
  assign mole_edge  = |(key_edge & mole_reg);
  assign wrong_edge = |(key_edge & ~mole_reg);

  // Hole choice; a repeat of the previous hole is bumped to the next one.
  assign idx_raw = lfsr_reg[7:0] % 8'(NUM_HOLES);
  assign idx_inc = (idx_raw == 8'(NUM_HOLES - 1)) ? 8'd0 : idx_raw + 8'd1;

  for (genvar gi = 0; gi < NUM_HOLES; gi++) begin : g_dec
    assign raw_oh[gi] = (idx_raw == 8'(gi));
    assign inc_oh[gi] = (idx_inc == 8'(gi));
  end

  assign spawn_oh = (raw_oh == prev_mole_reg) ? inc_oh : raw_oh;

  assign bus.mole           = mole_reg;
  assign bus.hit_miss       = hit_miss_reg;
  assign bus.control_signal = control_reg;
  assign bus.timer_signal   = timer_reg;
  assign bus.score          = score_reg;
  assign bus.misses         = misses_reg;

  // Free-running LFSR plus one-cycle history of keys and game_start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_reg <= SEED;
      keys_q   <= '0;
      start_q  <= 1'b0;
    end else begin
      lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
      keys_q   <= bus.keys;
      start_q  <= bus.game_start;
    end
  end

  // Round FSM with all player-visible and handshake outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      mole_reg      <= '0;
      prev_mole_reg <= '0;
      hit_miss_reg  <= 2'b00;
      control_reg   <= 1'b0;
      timer_reg     <= 1'b0;
      score_reg     <= '0;
      misses_reg    <= '0;
      mole_cnt_reg  <= '0;
      fb_cnt_reg    <= '0;
      game_cnt_reg  <= GC_W'(GAME_CYCLES - 1);
    end else begin
      case (state_reg)
        S_IDLE: begin
          score_reg    <= '0;
          misses_reg   <= '0;
          game_cnt_reg <= GC_W'(GAME_CYCLES - 1);
          if (start_q && !bus.game_start) begin
            control_reg <= 1'b1;
            state_reg   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (bus.game_active) begin
            control_reg <= 1'b0;
            state_reg   <= S_SPAWN;
          end
        end
        S_SPAWN: begin
          mole_reg      <= spawn_oh;
          prev_mole_reg <= spawn_oh;
          mole_cnt_reg  <= MC_W'(MOLE_CYCLES - 1);
          if (game_cnt_reg != '0) game_cnt_reg <= game_cnt_reg - 1'b1;
          state_reg     <= S_UP;
        end
        S_UP: begin
          if (game_cnt_reg == '0) begin
            // Round over: the mole simply vanishes, no score change.
            mole_reg  <= '0;
            timer_reg <= 1'b1;
            state_reg <= S_TIMEOUT;
          end else begin
            game_cnt_reg <= game_cnt_reg - 1'b1;
            if (wrong_edge || (!mole_edge && mole_cnt_reg == '0)) begin
              hit_miss_reg <= 2'b10;
              misses_reg   <= (&misses_reg) ? misses_reg : misses_reg + 1'b1;
              mole_reg     <= '0;
              state_reg    <= S_REPORT;
            end else if (mole_edge) begin
              hit_miss_reg <= 2'b01;
              score_reg    <= (&score_reg) ? score_reg : score_reg + 1'b1;
              mole_reg     <= '0;
              state_reg    <= S_REPORT;
            end else begin
              mole_cnt_reg <= mole_cnt_reg - 1'b1;
            end
          end
        end
        S_REPORT: begin
          if (!bus.game_active) begin
            hit_miss_reg <= 2'b00;
            fb_cnt_reg   <= FC_W'(FEEDBACK_CYCLES - 1);
            state_reg    <= S_FEEDBACK;
          end
        end
        S_FEEDBACK: begin
          if (control_reg && bus.game_active) begin
            control_reg <= 1'b0;
            state_reg   <= S_SPAWN;
          end else if (fb_cnt_reg == '0) begin
            control_reg <= 1'b1;
          end else begin
            fb_cnt_reg <= fb_cnt_reg - 1'b1;
          end
        end
        S_TIMEOUT: begin
          if (timer_reg) begin
            if (!bus.game_active) begin
              timer_reg   <= 1'b0;
              control_reg <= 1'b1;
            end
          end else if (bus.game_end) begin
            control_reg <= 1'b0;
            state_reg   <= S_END;
          end
        end
        S_END: begin
          if (!bus.game_end) state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Directed bench for mole_round_ctrl: stimulus pushes expected hit/miss/timer
// events into a scoreboard, an independent monitor pops them when they appear.
module tb_mole_round_ctrl;
  localparam int NH = 4;
  localparam int SW = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mole_round_if #(.NUM_HOLES(NH), .SCORE_W(SW)) bus ();

  mole_round_ctrl #(
    .NUM_HOLES(NH), .MOLE_CYCLES(10), .FEEDBACK_CYCLES(4),
    .GAME_CYCLES(100), .SCORE_W(SW), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  typedef struct {
    logic [1:0]    hm;
    logic          tmr;
    logic [SW-1:0] sc;
    logic [SW-1:0] ms;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            rise_cyc = 0;
  logic [NH-1:0] cur_mole, first_mole, other;
  logic [SW-1:0] exp_sc = '0;
  logic [SW-1:0] exp_ms = '0;
  logic [1:0]    mon_hm = 2'b00;
  logic          mon_t = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endfunction

  function automatic void expect_ev(input logic [1:0] hm, input logic tmr, input int c);
    exp_t e;
    e.hm  = hm;
    e.tmr = tmr;
    e.sc  = exp_sc;
    e.ms  = exp_ms;
    e.cyc = c;
    sb.push_back(e);
  endfunction

  // Monitor: pop one expectation each time a hit/miss or timer event appears.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset_n) begin
      if (bus.hit_miss != 2'b00 && bus.timer_signal) begin
        n_vec++;
        n_err++;
        $display("FAIL excl: got hit_miss=%b timer=1, required never both", bus.hit_miss);
      end
      if ((bus.hit_miss != 2'b00 && mon_hm == 2'b00) || (bus.timer_signal && !mon_t)) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_event: got hit_miss=%b timer=%b, required no event",
                   bus.hit_miss, bus.timer_signal);
        end else begin
          e = sb.pop_front();
          check("ev_hit_miss", 32'(bus.hit_miss), 32'(e.hm));
          check("ev_timer", 32'(bus.timer_signal), 32'(e.tmr));
          check("ev_score", 32'(bus.score), 32'(e.sc));
          check("ev_misses", 32'(bus.misses), 32'(e.ms));
          check("ev_mole_clear", 32'(bus.mole), 0);
          check("ev_cycle", cyc, e.cyc);
        end
      end
    end
    mon_hm = bus.hit_miss;
    mon_t  = bus.timer_signal;
  end

  task automatic reset_seq();
    reset_n         = 1'b0;
    bus.game_start  = 1'b0;
    bus.game_active = 1'b0;
    bus.game_end    = 1'b0;
    bus.keys        = '0;
    repeat (3) @(negedge clk);
    check("rst_mole", 32'(bus.mole), 0);
    check("rst_hit_miss", 32'(bus.hit_miss), 0);
    check("rst_control", 32'(bus.control_signal), 0);
    check("rst_timer", 32'(bus.timer_signal), 0);
    check("rst_score", 32'(bus.score), 0);
    check("rst_misses", 32'(bus.misses), 0);
    reset_n = 1'b1;
  endtask

  task automatic start_round();
    bus.game_start = 1'b1;
    repeat (2) @(negedge clk);
    bus.game_start = 1'b0;
    @(negedge clk);
    check("start_ctrl_high", 32'(bus.control_signal), 1);
    bus.game_active = 1'b1;
    @(negedge clk);
    check("load_ctrl_low", 32'(bus.control_signal), 0);
    @(negedge clk);
    check("spawn_onehot", 32'($onehot(bus.mole)), 1);
    cur_mole = bus.mole;
    rise_cyc = cyc;
  endtask

  task automatic wait_event(input string nm);
    int n = 0;
    while (bus.hit_miss == 2'b00 && !bus.timer_signal && n < 25) begin
      @(negedge clk);
      n++;
    end
    if (n >= 25) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_wait: got no event in 25 cycles, required hit/miss/timer", nm);
    end
  endtask

  // Close the report, run the feedback window and check the next mole.
  task automatic next_mole(input logic release_keys);
    if (release_keys) bus.keys = '0;
    bus.game_active = 1'b0;
    @(negedge clk);
    check("report_hm_clear", 32'(bus.hit_miss), 0);
    repeat (3) @(negedge clk);
    check("feedback_ctrl_low", 32'(bus.control_signal), 0);
    @(negedge clk);
    check("feedback_ctrl_high", 32'(bus.control_signal), 1);
    bus.game_active = 1'b1;
    @(negedge clk);
    check("resume_ctrl_low", 32'(bus.control_signal), 0);
    @(negedge clk);
    check("respawn_onehot", 32'($onehot(bus.mole)), 1);
    check("respawn_differs", 32'(bus.mole != cur_mole), 1);
    cur_mole = bus.mole;
    rise_cyc = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 time units, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_seq();
    start_round();
    first_mole = cur_mole;

    // Hit on the first UP cycle: 2 active cycles used.
    bus.keys = cur_mole;
    exp_sc = 1;
    expect_ev(2'b01, 1'b0, rise_cyc + 1);
    wait_event("hit");
    next_mole(1'b1);

    // No key: timeout miss 10 cycles after rise, 11 active cycles used.
    exp_ms = 1;
    expect_ev(2'b10, 1'b0, rise_cyc + 10);
    wait_event("timeout");
    check("timeout_score_kept", 32'(bus.score), 1);
    next_mole(1'b1);

    // Mole key plus a wrong key together is a miss; 2 active cycles.
    other = {cur_mole[NH-2:0], cur_mole[NH-1]};
    bus.keys = cur_mole | other;
    exp_ms = 2;
    expect_ev(2'b10, 1'b0, rise_cyc + 1);
    wait_event("simultaneous");
    next_mole(1'b0);

    // Keys held through SPAWN give nothing until released and repressed.
    @(negedge clk);
    check("held_no_event1", 32'(bus.hit_miss), 0);
    @(negedge clk);
    check("held_no_event2", 32'(bus.hit_miss), 0);
    bus.keys = '0;
    @(negedge clk);
    bus.keys = cur_mole;
    exp_sc = 2;
    expect_ev(2'b01, 1'b0, rise_cyc + 4);
    wait_event("repress");
    next_mole(1'b1);

    // 20 of 100 active cycles used; seven timeouts use 77 more.
    for (int i = 0; i < 7; i++) begin
      exp_ms = exp_ms + 1'b1;
      expect_ev(2'b10, 1'b0, rise_cyc + 10);
      wait_event("run_down");
      next_mole(1'b1);
    end

    // Three cycles left: expiry on the second UP cycle beats a key edge.
    @(negedge clk);
    bus.keys = cur_mole;
    expect_ev(2'b00, 1'b1, rise_cyc + 2);
    wait_event("expiry");
    check("expiry_score_kept", 32'(bus.score), 2);
    bus.keys = '0;
    bus.game_active = 1'b0;
    @(negedge clk);
    check("timeout_ctrl_high", 32'(bus.control_signal), 1);
    check("timeout_timer_low", 32'(bus.timer_signal), 0);
    bus.game_end = 1'b1;
    @(negedge clk);
    check("end_ctrl_low", 32'(bus.control_signal), 0);
    @(negedge clk);
    check("end_score_frozen", 32'(bus.score), 2);
    check("end_misses_frozen", 32'(bus.misses), 9);
    bus.game_end = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_score_clear", 32'(bus.score), 0);
    check("idle_misses_clear", 32'(bus.misses), 0);

    // New round, hit, then asynchronous reset while the hit is reported.
    exp_sc = 0;
    exp_ms = 0;
    start_round();
    bus.keys = cur_mole;
    exp_sc = 1;
    expect_ev(2'b01, 1'b0, rise_cyc + 1);
    wait_event("pre_reset_hit");
    #2;
    reset_n = 1'b0;
    #1;
    check("async_hit_miss", 32'(bus.hit_miss), 0);
    check("async_score", 32'(bus.score), 0);
    check("async_control", 32'(bus.control_signal), 0);
    reset_seq();
    start_round();
    check("restart_same_mole", 32'(cur_mole), 32'(first_mole));
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
